// File: rtl/permute_scheduler.sv
// permute_scheduler
//   Round-robin scheduler that shares one permute core between NREQ requesters.
//   The winner's file index is latched at grant. perm_start is held for
//   START_CYCLES cycles, then perm_finish is awaited. A one-cycle done pulse
//   goes back to the winner, followed by one idle cycle before the next
//   arbitration.
//
//   Optional feature macro: PERM_TIMEOUT_EN
//     When defined, a WAIT-state watchdog ends a job after TIMEOUT_CYCLES
//     cycles without finish. It pulses err (not done) to the winner.
//     When undefined, no watchdog exists, err is tied to 0, and WAIT lasts
//     until finish arrives.
//
// Ports
//   clk              in   clock, rising edge
//   rst_n            in   asynchronous active-low reset
//   req              in   [NREQ]       request level per requester, held until done
//   req_idx          in   [NREQ*IDXW]  requester i's file index at [i*IDXW +: IDXW]
//   grant            out  [NREQ]       one-hot, high from grant to done inclusive
//   done             out  [NREQ]       one-cycle completion pulse to the winner
//   err              out  [NREQ]       one-cycle timeout pulse to the winner
//   busy             out  high whenever the FSM is not IDLE
//   perm_start       out  permute start, high for START_CYCLES cycles per job
//   perm_file_index  out  [IDXW]       latched file index of the current/last job
//   perm_finish      in   permute finish level, sampled only in WAIT

module permute_scheduler #(
  parameter int NREQ           = 4,
  parameter int IDXW           = 10,
  parameter int START_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*IDXW-1:0] req_idx,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      done,
  output logic [NREQ-1:0]      err,
  output logic                 busy,
  output logic                 perm_start,
  output logic [IDXW-1:0]      perm_file_index,
  input  logic                 perm_finish
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SCW  = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [PTRW-1:0] ptr_q, ptr_d;
  logic [IDXW-1:0] fidx_q, fidx_d;
  logic [SCW-1:0]  scnt_q, scnt_d;

`ifdef PERM_TIMEOUT_EN
  localparam int WDW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WDW-1:0] wd_q, wd_d;
  logic           tout_q, tout_d;   // current job ended by the watchdog
`endif

  // Round-robin pick: first asserted request at or after ptr_q, wrapping.
  logic            pick_valid;
  logic [PTRW-1:0] pick;
  logic [PTRW-1:0] cand;

  always_comb begin
    pick_valid = 1'b0;
    pick       = '0;
    cand       = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = PTRW'((int'(ptr_q) + k) % NREQ);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick       = cand;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    fidx_d  = fidx_q;
    scnt_d  = scnt_q;
`ifdef PERM_TIMEOUT_EN
    wd_d    = wd_q;
    tout_d  = tout_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          state_d = S_START;
          grant_d = NREQ'(1) << pick;
          fidx_d  = req_idx[int'(pick)*IDXW +: IDXW];
          ptr_d   = (pick == PTRW'(NREQ - 1)) ? '0 : pick + 1'b1;
          scnt_d  = '0;
`ifdef PERM_TIMEOUT_EN
          wd_d    = '0;
          tout_d  = 1'b0;
`endif
        end
      end
      S_START: begin
        // Any finish level seen here belongs to the previous job; ignore it.
        if (scnt_q == SCW'(START_CYCLES - 1)) state_d = S_WAIT;
        else                                  scnt_d  = scnt_q + 1'b1;
      end
      S_WAIT: begin
        if (perm_finish) begin
          state_d = S_DONE;
        end
`ifdef PERM_TIMEOUT_EN
        else if (wd_q == WDW'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_DONE;
          tout_d  = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      S_DONE: begin
        // The idle cycle that follows is what spaces consecutive jobs apart.
        state_d = S_IDLE;
        grant_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      fidx_q  <= '0;
      scnt_q  <= '0;
`ifdef PERM_TIMEOUT_EN
      wd_q    <= '0;
      tout_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      fidx_q  <= fidx_d;
      scnt_q  <= scnt_d;
`ifdef PERM_TIMEOUT_EN
      wd_q    <= wd_d;
      tout_q  <= tout_d;
`endif
    end
  end

  // Outputs decode straight from registered state, so an async reset
  // clears them immediately without waiting for an edge.
  assign grant           = grant_q;
  assign busy            = (state_q != S_IDLE);
  assign perm_start      = (state_q == S_START);
  assign perm_file_index = fidx_q;

`ifdef PERM_TIMEOUT_EN
  assign done = (state_q == S_DONE && !tout_q) ? grant_q : '0;
  assign err  = (state_q == S_DONE &&  tout_q) ? grant_q : '0;
`else
  assign done = (state_q == S_DONE) ? grant_q : '0;
  assign err  = '0;
`endif

endmodule

// File: tb/tb_permute_scheduler.sv
// Self-checking bench for permute_scheduler. A small permute-core model
// raises finish a programmable number of cycles after start ends. A
// scoreboard of expected (winner, file index) pairs is filled as requests
// are driven and is drained by a monitor when each grant appears.

module tb_permute_scheduler;

  localparam int NREQ           = 4;
  localparam int IDXW           = 10;
  localparam int START_CYCLES   = 2;
  localparam int TIMEOUT_CYCLES = 16;

  logic                 clk         = 1'b0;
  logic                 rst_n       = 1'b0;
  logic [NREQ-1:0]      req         = '0;
  logic [NREQ*IDXW-1:0] req_idx     = '0;
  logic                 perm_finish = 1'b0;
  logic [NREQ-1:0]      grant, done, err;
  logic                 busy, perm_start;
  logic [IDXW-1:0]      perm_file_index;

  permute_scheduler #(
    .NREQ          (NREQ),
    .IDXW          (IDXW),
    .START_CYCLES  (START_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (req),
    .req_idx        (req_idx),
    .grant          (grant),
    .done           (done),
    .err            (err),
    .busy           (busy),
    .perm_start     (perm_start),
    .perm_file_index(perm_file_index),
    .perm_finish    (perm_finish)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- scoreboard
  typedef struct {
    int              g;
    logic [IDXW-1:0] fi;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  task automatic push(input int g, input int fi);
    exp_t e;
    e.g  = g;
    e.fi = IDXW'(fi);
    sb_q.push_back(e);
  endtask

  // ---------------------------------------------------------- permute model
  int finish_delay = 10;
  bit never_finish = 1'b0;
  bit glitch_start = 1'b0;   // misbehaving core: finish high during start
  bit model_run    = 1'b0;
  int model_cnt    = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      perm_finish = 1'b0;
      model_run   = 1'b0;
      model_cnt   = 0;
    end else if (perm_start) begin
      perm_finish = glitch_start;
      model_run   = 1'b1;
      model_cnt   = 0;
    end else if (model_run) begin
      model_cnt++;
      perm_finish = !never_finish && (model_cnt >= finish_delay);
    end
  end

  // ---------------------------------------------------------------- monitor
  int              cyc = 0;
  logic [NREQ-1:0] prev_grant = '0;
  bit              prev_start = 1'b0;
  bit              end_pending = 1'b0;
  bit              last_end_valid = 1'b0;
  bit              gap_en = 1'b0;
  int              start_cnt = 0;
  int              fall_cyc = 0;
  int              last_end_cyc = 0;
  int              jobs_done = 0;
  int              errs_seen = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_grant     = '0;
      prev_start     = 1'b0;
      end_pending    = 1'b0;
      last_end_valid = 1'b0;
      start_cnt      = 0;
    end else begin
      if (end_pending) begin
        check("cleanup_grant", 32'(grant), 32'd0);
        check("cleanup_done",  32'(done),  32'd0);
        check("cleanup_err",   32'(err),   32'd0);
        check("cleanup_busy",  32'(busy),  32'd0);
        end_pending = 1'b0;
      end
      if (grant != '0 && prev_grant == '0) begin
        if (sb_q.size() == 0) begin
          check("unexpected_grant", 32'(grant), 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check("grant_onehot",   32'(grant), 32'd1 << mon_e.g);
          check("file_index",     32'(perm_file_index), 32'(mon_e.fi));
          check("start_at_grant", 32'(perm_start), 32'd1);
          check("busy_at_grant",  32'(busy), 32'd1);
        end
        if (gap_en && last_end_valid) check("idle_gap", 32'(cyc - last_end_cyc), 32'd2);
        start_cnt = 0;
      end
      if (perm_start) start_cnt++;
      if (prev_start && !perm_start) begin
        check("start_len", 32'(start_cnt), 32'(START_CYCLES));
        fall_cyc = cyc;
      end
      if (done != '0) begin
        check("done_matches_grant", 32'(done), 32'(grant));
        check("done_latency", 32'(cyc - fall_cyc), 32'(finish_delay));
        check("err_with_done", 32'(err), 32'd0);
        jobs_done++;
        end_pending    = 1'b1;
        last_end_valid = 1'b1;
        last_end_cyc   = cyc;
      end
      if (err != '0) begin
`ifdef PERM_TIMEOUT_EN
        check("err_matches_grant", 32'(err), 32'(grant));
        check("timeout_len", 32'(cyc - fall_cyc), 32'(TIMEOUT_CYCLES));
        errs_seen++;
        end_pending = 1'b1;
`else
        check("unexpected_err", 32'(err), 32'd0);
`endif
      end
      prev_grant = grant;
      prev_start = perm_start;
    end
  end

  // ----------------------------------------------------------------- helpers
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req   = '0;
    sb_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic set_idx(input int base);
    for (int i = 0; i < NREQ; i++) req_idx[i*IDXW +: IDXW] = IDXW'(base + i);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic wait_grant(output int lat);
    lat = 0;
    while (grant == '0 && lat < 20) begin
      tick();
      lat++;
    end
    check("grant_seen", 32'(grant != '0), 32'd1);
  endtask

  task automatic wait_start_low();
    int n = 0;
    while (perm_start && n < 20) begin
      tick();
      n++;
    end
    check("start_dropped", 32'(perm_start), 32'd0);
  endtask

  task automatic wait_jobs(input int target, input int budget);
    int n = 0;
    while (jobs_done < target && n < budget) begin
      tick();
      n++;
    end
    check("jobs_done", 32'(jobs_done), 32'(target));
  endtask

  // One job from IDLE: request, expect grant next edge, drop request and
  // scramble the indices right after grant, then wait for done.
  task automatic run_vec(input logic [NREQ-1:0] r, input int base, input int g, input int delay);
    int lat;
    int target;
    wait_idle(20);
    finish_delay = delay;
    set_idx(base);
    push(g, base + g);
    target = jobs_done + 1;
    req    = r;
    wait_grant(lat);
    check("grant_latency", 32'(lat), 32'd1);
    req     = '0;
    req_idx = '1;
    wait_jobs(target, 200);
  endtask

  typedef struct {
    logic [NREQ-1:0] req;
    int              base;
    int              exp_g;
    int              delay;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  // ------------------------------------------------------------------ tests
  initial begin
    int lat;
    int target;
    int j0;

    // Round-robin sequence starting from ptr=1 (left there by test 4).
    tbl[0] = '{4'b0001,  100, 0, 1};
    tbl[1] = '{4'b1001,  200, 3, 2};
    tbl[2] = '{4'b1001,  300, 0, 3};
    tbl[3] = '{4'b0110,  400, 1, 4};
    tbl[4] = '{4'b0110,  500, 2, 5};
    tbl[5] = '{4'b0011,  600, 0, 1};
    tbl[6] = '{4'b1100,  700, 2, 2};
    tbl[7] = '{4'b1111,  800, 3, 3};
    tbl[8] = '{4'b1000,  900, 3, 4};
    tbl[9] = '{4'b0100, 1000, 2, 5};

    // Test 1: reset values, then a single job for requester 0, index 5.
    apply_reset();
    check("rst_grant",      32'(grant), 32'd0);
    check("rst_done",       32'(done), 32'd0);
    check("rst_err",        32'(err), 32'd0);
    check("rst_busy",       32'(busy), 32'd0);
    check("rst_perm_start", 32'(perm_start), 32'd0);
    check("rst_file_index", 32'(perm_file_index), 32'd0);
    run_vec(4'b0001, 5, 0, 10);
    tick();
    check("index_held_1", 32'(perm_file_index), 32'd5);

    // Test 2: all four held from ptr=0 -> 0,1,2,3,0 with one idle cycle between.
    apply_reset();
    gap_en       = 1'b1;
    finish_delay = 4;
    set_idx(0);
    push(0, 0); push(1, 1); push(2, 2); push(3, 3); push(0, 0);
    target = jobs_done + 5;
    req    = 4'b1111;
    wait_jobs(target, 400);
    req = '0;

    // Test 3: only 1 and 3 held from ptr=0 -> 1,3,1,3.
    apply_reset();
    finish_delay = 6;
    set_idx(30);
    push(1, 31); push(3, 33); push(1, 31); push(3, 33);
    target = jobs_done + 4;
    req    = 4'b1010;
    wait_jobs(target, 400);
    req    = '0;
    gap_en = 1'b0;

    // Test 4: requester 0 drops its request during WAIT; job still completes.
    wait_idle(20);
    finish_delay = 12;
    set_idx(200);
    push(0, 200);
    target = jobs_done + 1;
    req    = 4'b0001;
    wait_grant(lat);
    check("grant_latency_t4", 32'(lat), 32'd1);
    wait_start_low();
    req     = '0;
    req_idx = '1;
    wait_jobs(target, 100);
    repeat (6) tick();
    check("no_regrant", 32'(grant), 32'd0);
    check("index_held_2", 32'(perm_file_index), 32'd200);

    // Table-driven round-robin vectors.
    for (int e = 0; e < 10; e++) run_vec(tbl[e].req, tbl[e].base, tbl[e].exp_g, tbl[e].delay);

    // Finish held high through START must not complete the job early.
    glitch_start = 1'b1;
    run_vec(4'b0001, 50, 0, 3);
    glitch_start = 1'b0;

    // Test 5: async reset mid-WAIT clears outputs before the next edge,
    // and the pointer restarts at 0 (ptr was 2 after granting requester 1).
    wait_idle(20);
    finish_delay = 50;
    set_idx(40);
    push(1, 41);
    req = 4'b0010;
    wait_grant(lat);
    req = '0;
    wait_start_low();
    repeat (3) tick();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_grant",      32'(grant), 32'd0);
    check("mid_rst_busy",       32'(busy), 32'd0);
    check("mid_rst_perm_start", 32'(perm_start), 32'd0);
    check("mid_rst_file_index", 32'(perm_file_index), 32'd0);
    sb_q.delete();
    repeat (2) tick();
    finish_delay = 5;
    set_idx(60);
    push(1, 61);
    target = jobs_done + 1;
    req    = 4'b0110;
    rst_n  = 1'b1;
    wait_grant(lat);
    req = '0;
    wait_jobs(target, 100);

    // Test 6: core never finishes (ptr=2, so requester 2 wins).
    wait_idle(20);
    never_finish = 1'b1;
    set_idx(70);
    push(2, 72);
    j0  = jobs_done;
    req = 4'b0100;
    wait_grant(lat);
    req = '0;
`ifdef PERM_TIMEOUT_EN
    begin
      int e0 = errs_seen;
      int n  = 0;
      while (errs_seen == e0 && n < 60) begin
        tick();
        n++;
      end
      check("timeout_err_seen", 32'(errs_seen), 32'(e0 + 1));
      check("timeout_no_done", 32'(jobs_done), 32'(j0));
      tick();
      check("timeout_back_idle", 32'(busy), 32'd0);
    end
    never_finish = 1'b0;
`else
    repeat (40) tick();
    check("wait_busy_held",  32'(busy), 32'd1);
    check("wait_grant_held", 32'(grant), 32'b0100);
    check("wait_no_done",    32'(jobs_done), 32'(j0));
    never_finish = 1'b0;
    apply_reset();
`endif

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
